// File: rtl/idli_uart_tx.sv
// idli_uart_tx: transmit end of the core's UART path.
//   Assembles a 16-bit word from four 4-bit slices (slice 0 = bits [3:0]),
//   queues completed words in a small FIFO, and sends each word as two
//   UART frames, low byte first, on o_tx.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   FIFO_DEPTH    words buffered (power of two, >= 2)
//
// Ports
//   i_clk       clock
//   i_rst       synchronous active-high reset
//   i_ctr       core slice counter, 0..3 selects the slice
//   i_wr_en     core writes this instruction's result (held all 4 cycles)
//   i_wr_slice  data slice for the current i_ctr
//   o_wr_ready  FIFO can take a word (sampled by the core at i_ctr==0)
//   o_tx        serial output, idle high
//   o_busy      FIFO non-empty or a frame in progress
//   o_overflow  one-cycle pulse when a word is dropped
//
// Build option
//   IDLI_UART_TX_PARITY_EN  adds an even-parity bit after the data (8E1)
//   otherwise 8N1.
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (parity build only)
// STOP   | stop bit (high), then next byte, next word or IDLE

module idli_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_ctr,
    input  logic       i_wr_en,
    input  logic [3:0] i_wr_slice,
    output logic       o_wr_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t          state;
    logic [BW-1:0]   baud;
    logic [2:0]      bit_cnt;
    logic            byte_sel;
    logic [15:0]     shreg;
`ifdef IDLI_UART_TX_PARITY_EN
    logic            par;
`endif

    logic [11:0]     asm_lo;
    logic            accept;
    logic            word_ok;

    logic [15:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;

    logic            baud_end;
    logic            push;
    logic            pop;
    logic [15:0]     fifo_rd;

    assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));
    // Slice 3 goes straight into the FIFO, so only the lower 12 bits are held.
    assign push     = i_wr_en && (i_ctr == 2'd3) && word_ok && accept;
    // A word leaves the FIFO from IDLE, or directly at the end of the second
    // stop bit so consecutive words go out with no idle gap.
    assign pop      = (count != '0) &&
                      ((state == S_IDLE) || ((state == S_STOP) && baud_end && byte_sel));
    assign fifo_rd  = mem[rd_ptr];
    assign o_busy   = (count != '0) || (state != S_IDLE);

    // Word capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            asm_lo     <= '0;
            accept     <= 1'b0;
            word_ok    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_overflow <= 1'b0;
            unique case (i_ctr)
                2'd0: begin
                    word_ok <= i_wr_en;
                    if (i_wr_en) begin
                        accept      <= o_wr_ready;
                        asm_lo[3:0] <= i_wr_slice;
                    end
                end
                2'd1: begin
                    if (i_wr_en) asm_lo[7:4] <= i_wr_slice;
                    else         word_ok     <= 1'b0;
                end
                2'd2: begin
                    if (i_wr_en) asm_lo[11:8] <= i_wr_slice;
                    else         word_ok      <= 1'b0;
                end
                2'd3: begin
                    if (i_wr_en && word_ok && !accept) o_overflow <= 1'b1;
                    word_ok <= 1'b0;
                end
            endcase
        end
    end

    // FIFO
    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (!push && pop) count_next = count - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= {i_wr_slice, asm_lo};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_wr_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            o_wr_ready <= (count_next < CW'(FIFO_DEPTH));
        end
    end

    // Transmit FSM; baud only leaves zero inside a bit, so it restarts on
    // every state change.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            o_tx     <= 1'b1;
            baud     <= '0;
            bit_cnt  <= '0;
            byte_sel <= 1'b0;
            shreg    <= '0;
`ifdef IDLI_UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            baud <= baud_end ? '0 : baud + 1'b1;
            case (state)
                S_IDLE: begin
                    baud <= '0;
                    if (pop) begin
                        shreg    <= fifo_rd;
                        byte_sel <= 1'b0;
                        state    <= S_START;
                        o_tx     <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        state   <= S_DATA;
                        o_tx    <= shreg[0];
                        bit_cnt <= '0;
`ifdef IDLI_UART_TX_PARITY_EN
                        par     <= 1'b0;
`endif
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        // After the eighth shift the high byte sits in [7:0].
                        shreg <= {1'b0, shreg[15:1]};
`ifdef IDLI_UART_TX_PARITY_EN
                        par   <= par ^ o_tx;
`endif
                        if (bit_cnt == 3'd7) begin
`ifdef IDLI_UART_TX_PARITY_EN
                            state <= S_PARITY;
                            o_tx  <= par ^ o_tx;
`else
                            state <= S_STOP;
                            o_tx  <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            o_tx    <= shreg[1];
                        end
                    end
                end
`ifdef IDLI_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_end) begin
                        state <= S_STOP;
                        o_tx  <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_end) begin
                        if (!byte_sel) begin
                            byte_sel <= 1'b1;
                            state    <= S_START;
                            o_tx     <= 1'b0;
                        end else if (pop) begin
                            shreg    <= fifo_rd;
                            byte_sel <= 1'b0;
                            state    <= S_START;
                            o_tx     <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            o_tx  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    o_tx  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idli_uart_tx.sv
// Bench for idli_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// The reference keeps the FIFO as a queue of words and the line as a queue
// of per-cycle levels expanded from each frame; outputs are compared every
// cycle on the falling edge, plus fixed waveform pins for known words.

module tb_idli_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef IDLI_UART_TX_PARITY_EN
    localparam int FBITS = 11;
    localparam logic [15:0] LIT_WORD = 16'h0107;
    bit lit_bits [2*FBITS] = '{0,1,1,1,0,0,0,0,0,1,1, 0,1,0,0,0,0,0,0,0,1,1};
`else
    localparam int FBITS = 10;
    localparam logic [15:0] LIT_WORD = 16'hA55A;
    bit lit_bits [2*FBITS] = '{0,0,1,0,1,1,0,1,0,1, 0,1,0,1,0,0,1,0,1,1};
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ctr = 2'd0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_slice = 4'd0;
    logic       wr_ready, tx, busy, overflow;

    int vectors = 0;
    int miscompares = 0;

    idli_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_ctr(ctr), .i_wr_en(wr_en),
        .i_wr_slice(wr_slice), .o_wr_ready(wr_ready), .o_tx(tx),
        .o_busy(busy), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    bit [15:0] mq[$];
    bit        lq[$];
    bit        m_tx = 1'b1, m_busy = 1'b0, m_ready = 1'b1, m_ovf = 1'b0;
    bit        m_accept = 1'b0, m_ok = 1'b0;
    bit [11:0] m_asm = '0;
    bit        rst_seen = 1'b0;
    bit        cmp_en = 1'b0;

    function automatic void expand(input bit [15:0] w);
        for (int k = 0; k < 2; k++) begin
            bit [7:0] b;
            b = w[8*k +: 8];
            for (int c = 0; c < CPB; c++) lq.push_back(1'b0);
            for (int i = 0; i < 8; i++)
                for (int c = 0; c < CPB; c++) lq.push_back(b[i]);
`ifdef IDLI_UART_TX_PARITY_EN
            for (int c = 0; c < CPB; c++) lq.push_back(^b);
`endif
            for (int c = 0; c < CPB; c++) lq.push_back(1'b1);
        end
    endfunction

    always @(posedge clk) begin
        bit in_frame;
        rst_seen = rst;
        if (rst) begin
            mq.delete();
            lq.delete();
            m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b1; m_ovf = 1'b0;
            m_ok = 1'b0; m_accept = 1'b0;
        end else begin
            if (lq.size() == 0 && mq.size() != 0) expand(mq.pop_front());
            in_frame = (lq.size() != 0);
            m_tx = in_frame ? lq.pop_front() : 1'b1;
            m_ovf = 1'b0;
            if (!wr_en) m_ok = 1'b0;
            else if (ctr == 2'd0) begin
                m_ok = 1'b1; m_accept = m_ready; m_asm[3:0] = wr_slice;
            end else if (ctr == 2'd3) begin
                if (m_ok) begin
                    if (m_accept) mq.push_back({wr_slice, m_asm});
                    else          m_ovf = 1'b1;
                end
                m_ok = 1'b0;
            end else begin
                m_asm[4*ctr +: 4] = wr_slice;
            end
            m_ready = (mq.size() < DEPTH);
            m_busy  = in_frame || (mq.size() != 0);
        end
    end

    int  ovf_cnt = 0;
    bit  saw_not_ready = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("tx", tx, m_tx);
            check("busy", busy, m_busy);
            check("wr_ready", wr_ready, m_ready);
            check("overflow", overflow, m_ovf);
            if (rst_seen) begin
                check("tx_after_rst", tx, 1'b1);
                check("busy_after_rst", busy, 1'b0);
            end
            if (overflow) ovf_cnt++;
            if (!wr_ready) saw_not_ready = 1'b1;
        end
    end

    // One 4-cycle slot: mode 0 idle, 1 full write, 2 drop after ctr1,
    // 3 drop after ctr0. rst_at selects a cycle of the slot to pulse reset.
    task automatic slot(input int mode, input logic [15:0] w, input int rst_at);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ctr      = 2'(k);
            wr_en    = (mode == 1) || (mode == 2 && k <= 1) || (mode == 3 && k == 0);
            wr_slice = w[4*k +: 4];
            rst      = (k == rst_at);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 300) begin
            slot(0, 16'h0, -1);
            n++;
        end
        check("drain_busy", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int          mode, r;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Idle after reset
        repeat (5) slot(0, 16'h0, -1);
        check("idle_tx", tx, 1'b1);
        check("idle_busy", busy, 1'b0);
        check("idle_ready", wr_ready, 1'b1);
        check("idle_ovf", overflow, 1'b0);

        // Known word: pinned waveform
        slot(1, LIT_WORD, -1);
        for (int i = 1; i <= 2 + 2*FBITS*CPB; i++) begin
            @(negedge clk);
            if (i == 1) check("lit_pop_cycle_tx", tx, 1'b1);
            if (i >= 3 && (i - 3) % CPB == 0 && (i - 3) / CPB < 2*FBITS)
                check($sformatf("lit_bit%0d", (i - 3) / CPB), tx, lit_bits[(i - 3) / CPB]);
            if (i == 1 + 2*FBITS*CPB) check("lit_busy_last", busy, 1'b1);
            if (i == 2 + 2*FBITS*CPB) check("lit_busy_done", busy, 1'b0);
            ctr   = ctr + 2'd1;
            wr_en = 1'b0;
        end
        repeat (2) slot(0, 16'h0, -1);

        // Six back-to-back writes: the sixth is dropped
        ovf_cnt = 0;
        saw_not_ready = 1'b0;
        for (int j = 0; j < 6; j++) slot(1, 16'(16'h1111 * (j + 1)), -1);
        repeat (2) slot(0, 16'h0, -1);
        check("burst_ovf_pulses", 16'(ovf_cnt), 16'd1);
        check("burst_not_ready", saw_not_ready, 1'b1);
        drain();

        // Reset during bit 3 of the first byte with a word queued
        slot(1, 16'h3C3C, -1);
        slot(1, 16'hBEEF, -1);
        repeat (3) slot(0, 16'h0, -1);
        slot(0, 16'h0, 1);
        repeat (30) slot(0, 16'h0, -1);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);

        // Abandoned write
        slot(2, 16'h1234, -1);
        repeat (5) slot(0, 16'h0, -1);
        check("abort_busy", busy, 1'b0);
        check("abort_tx", tx, 1'b1);

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      mode = 0;
            else if (r < 85) mode = 1;
            else if (r < 92) mode = 2;
            else             mode = 3;
            w = 16'($urandom);
            slot(mode, w, ($urandom_range(0, 99) < 2) ? $urandom_range(0, 3) : -1);
        end
        rst = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
